// File: rtl/bip_datapath_pkg.sv
// Shared BIP datapath definitions: widths, selA / ALU op encodings.
// Imported by the datapath, its data memory and the instruction decoder.
package bip_datapath_pkg;

  localparam int NB_DATA_DEF      = 16;
  localparam int NB_OPERAND_DEF   = 11;
  localparam int NB_DATA_ADDR_DEF = 10;

  typedef enum logic [1:0] {
    SELA_MEM = 2'b00,
    SELA_IMM = 2'b01,
    SELA_ALU = 2'b10,
    SELA_RSV = 2'b11
  } sela_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/bip_data_memory.sv
// BIP data memory: register array, synchronous write,
// combinational read gated by the read enable. Not reset.
module bip_data_memory
  import bip_datapath_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_DATA_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_wr,
  input  logic               i_rd,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_data
);

  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

  // write port: data lands at the clock edge
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      mem_q[i_addr] <= i_data;
    end
  end

  assign o_data = i_rd ? mem_q[i_addr] : '0;

endmodule

// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, add/sub ALU, data memory.
// Optional sticky signed-overflow flag with BIP_OVF_FLAG_EN.
module bip_datapath
  import bip_datapath_pkg::*;
#(
  parameter int NB_DATA      = NB_DATA_DEF,
  parameter int NB_OPERAND   = NB_OPERAND_DEF,
  parameter int NB_DATA_ADDR = NB_DATA_ADDR_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NB_OPERAND-1:0] i_operand,
  input  logic [1:0]            i_selA,
  input  logic                  i_selB,
  input  logic                  i_wr_Acc,
  input  logic                  i_op,
  input  logic                  i_wr_Ram,
  input  logic                  i_rd_Ram,
`ifdef BIP_OVF_FLAG_EN
  output logic                  o_overflow,
`endif
  output logic [NB_DATA-1:0]    o_acc,
  output logic                  o_zero,
  output logic                  o_neg
);

  localparam int MSB = NB_DATA - 1;

  logic [NB_DATA-1:0] acc_q;
  logic [NB_DATA-1:0] acc_d;
  logic               zero_q;
  logic               neg_q;

  logic [NB_DATA-1:0] imm;
  logic [NB_DATA-1:0] mem_rd;
  logic [NB_DATA-1:0] b_opnd;
  logic [NB_DATA-1:0] alu_res;
  logic [NB_DATA-1:0] acc_sel;
  logic               acc_wr;

  assign imm = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}},
                i_operand};

  bip_data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_DATA_ADDR)
  ) u_mem (
    .i_clk  (i_clk),
    .i_wr   (i_wr_Ram),
    .i_rd   (i_rd_Ram),
    .i_addr (i_operand[NB_DATA_ADDR-1:0]),
    .i_data (acc_q),
    .o_data (mem_rd)
  );

  assign b_opnd  = i_selB ? imm : mem_rd;
  assign alu_res = (i_op == OP_SUB) ? acc_q - b_opnd
                                    : acc_q + b_opnd;

  // accumulator source mux; reserved select behaves as a NOP
  always_comb begin
    acc_sel = acc_q;
    acc_wr  = 1'b0;
    unique case (i_selA)
      SELA_MEM: begin
        acc_sel = mem_rd;
        acc_wr  = i_wr_Acc;
      end
      SELA_IMM: begin
        acc_sel = imm;
        acc_wr  = i_wr_Acc;
      end
      SELA_ALU: begin
        acc_sel = alu_res;
        acc_wr  = i_wr_Acc;
      end
      default: begin
        acc_sel = acc_q;
        acc_wr  = 1'b0;
      end
    endcase
  end

  assign acc_d = acc_wr ? acc_sel : acc_q;

  // accumulator and flags follow the value being written
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q  <= '0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      zero_q <= (acc_d == '0);
      neg_q  <= acc_d[MSB];
    end
  end

  assign o_acc  = acc_q;
  assign o_zero = zero_q;
  assign o_neg  = neg_q;

`ifdef BIP_OVF_FLAG_EN
  logic ovf_q;
  logic ovf_d;
  logic sgn_ok;
  logic ovf_alu;

  // add wants equal signs, sub wants differing signs
  assign sgn_ok  = (i_op == OP_SUB) ? (acc_q[MSB] ^ b_opnd[MSB])
                                    : ~(acc_q[MSB] ^ b_opnd[MSB]);
  assign ovf_alu = sgn_ok & (alu_res[MSB] ^ acc_q[MSB]);
  assign ovf_d   = ovf_q |
                   (i_wr_Acc & (i_selA == SELA_ALU) & ovf_alu);

  // sticky overflow, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_bip_datapath.sv
// Scoreboard bench for bip_datapath: directed + random programs
// checked against a plain-arithmetic accumulator/memory model.
module tb_bip_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opd;
  logic [1:0]  sela;
  logic        selb;
  logic        wacc;
  logic        op;
  logic        wram;
  logic        rram;
  logic [15:0] acc;
  logic        zero;
  logic        neg;
`ifdef BIP_OVF_FLAG_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] acc;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t q[$];

  int          m_acc;
  bit          m_ovf;
  logic [15:0] m_mem [1024];
  bit          m_vld [1024];

  always #5 clk = ~clk;

  bip_datapath dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_operand (opd),
    .i_selA    (sela),
    .i_selB    (selb),
    .i_wr_Acc  (wacc),
    .i_op      (op),
    .i_wr_Ram  (wram),
    .i_rd_Ram  (rram),
`ifdef BIP_OVF_FLAG_EN
    .o_overflow(ovf),
`endif
    .o_acc     (acc),
    .o_zero    (zero),
    .o_neg     (neg)
  );

  function automatic int w16(input int v);
    return ((v % 65536) + 65536) % 65536;
  endfunction

  function automatic int s16(input int v);
    int u;
    u = w16(v);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, req, $time);
    end
  endtask

  // drive one instruction, advance the model, queue expected state
  task automatic step(input logic r, input logic [1:0] sa,
                      input logic sb, input logic wa,
                      input logic o, input logic wr,
                      input logic rd, input logic [10:0] v);
    int   addr, imm, mrd, b, res, rs;
    bit   ov;
    exp_t e;
    rst = r; sela = sa; selb = sb; wacc = wa;
    op = o; wram = wr; rram = rd; opd = v;
    addr = int'(v) % 1024;
    imm  = (v >= 11'd1024) ? int'(v) - 2048 : int'(v);
    mrd  = rd ? int'(m_mem[addr]) : 0;
    b    = sb ? w16(imm) : mrd;
    res  = o ? m_acc - b : m_acc + b;
    rs   = o ? s16(m_acc) - s16(b) : s16(m_acc) + s16(b);
    ov   = (rs > 32767) || (rs < -32768);
    if (wr) begin
      m_mem[addr] = 16'(m_acc);
      m_vld[addr] = 1'b1;
    end
    if (r) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end else if (wa) begin
      case (sa)
        2'd0: m_acc = mrd;
        2'd1: m_acc = w16(imm);
        2'd2: begin
          m_acc = w16(res);
          if (ov) m_ovf = 1'b1;
        end
        default: ;
      endcase
    end
    e.acc  = 16'(m_acc);
    e.zero = (m_acc == 0);
    e.neg  = (m_acc >= 32768);
    e.ovf  = m_ovf;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic ldi(input logic [10:0] v);
    step(0, 2'd1, 0, 1, 0, 0, 0, v);
  endtask
  task automatic sto(input logic [10:0] a);
    step(0, 2'd0, 0, 0, 0, 1, 0, a);
  endtask
  task automatic ld(input logic [10:0] a, input logic rd);
    step(0, 2'd0, 0, 1, 0, 0, rd, a);
  endtask
  task automatic alui(input logic o, input logic [10:0] v);
    step(0, 2'd2, 1, 1, o, 0, 0, v);
  endtask
  task automatic addm(input logic [10:0] a);
    step(0, 2'd2, 0, 1, 0, 0, 1, a);
  endtask

  // monitor: one architectural update per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("acc",  int'(acc),  int'(e.acc));
        chk("zero", int'(zero), int'(e.zero));
        chk("neg",  int'(neg),  int'(e.neg));
`ifdef BIP_OVF_FLAG_EN
        chk("ovf",  int'(ovf),  int'(e.ovf));
`endif
      end
    end
  end

  initial begin
    logic [10:0] v;
    logic [1:0]  sa;
    logic        rd;
    m_acc = 0;
    m_ovf = 1'b0;
    foreach (m_vld[i]) m_vld[i] = 1'b0;
    foreach (m_mem[i]) m_mem[i] = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    ldi(11'h7FF);
    ldi(11'h3FF);
    ldi(11'h234);
    for (int i = 0; i < 4; i++) alui(1, 11'h400);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    ldi(11'd5);
    sto(11'd3);
    ldi(11'd0);
    ld(11'd3, 1);
    ld(11'd3, 0);
    ldi(11'd5);
    alui(1, 11'd5);
    alui(0, 11'h7FF);
    ldi(11'h010);
    step(0, 2'd1, 0, 1, 0, 1, 0, 11'h407);
    ld(11'd7, 1);
    ld(11'h407, 1);
    ldi(11'h033);
    step(0, 2'd0, 0, 1, 0, 1, 1, 11'd7);
    ld(11'd7, 1);
    step(0, 2'd3, 1, 1, 0, 0, 0, 11'h123);
    step(1, 2'd0, 0, 0, 0, 1, 0, 11'd9);
    ld(11'd9, 1);
    step(0, 0, 0, 0, 0, 0, 0, 11'h555);
    ldi(11'h3FF);
    for (int i = 0; i < 5; i++) begin
      sto(11'd0);
      addm(11'd0);
    end
    alui(0, 11'h01F);
    sto(11'd0);
    addm(11'd0);
    ldi(11'd1);
    step(0, 2'd3, 0, 1, 0, 0, 0, 0);
    alui(0, 11'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      ldi(11'($urandom));
      sto(11'(i));
    end
    for (int n = 0; n < 600; n++) begin
      v  = 11'($urandom);
      if (($urandom % 2) == 0) v[9:4] = '0;
      sa = 2'($urandom);
      rd = 1'($urandom);
      if (!m_vld[int'(v) % 1024]) rd = 1'b0;
      step(($urandom % 60) == 0, sa, 1'($urandom),
           ($urandom % 4) != 0, 1'($urandom),
           ($urandom % 3) == 0, rd, v);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
